// File: rtl/pe_line_drain.sv
// Snapshot of the 10-PE accumulator line, requantized to int8 (one 48-bit or two
// 24-bit lanes) and streamed out one PE per beat over valid/ready.
module pe_line_drain #(
    parameter int NUM_PE = 10,
    parameter int ACC_W  = 48,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    split,
    input  logic [5:0]              shift,
    input  logic [NUM_PE*ACC_W-1:0] in_acc,
    input  logic                    cap_valid,
    output logic                    cap_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last,
    output logic [1:0]              out_sat,
    output logic                    cap_drop
);

    localparam int LANE_W = ACC_W / 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
    localparam logic [5:0] MAX_S_FULL  = 6'(ACC_W - 1);
    localparam logic [5:0] MAX_S_SPLIT = 6'(LANE_W - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0] in_words [NUM_PE];
    logic [ACC_W-1:0] snap     [NUM_PE];
    logic             snap_split;
    logic [5:0]       snap_shift;
    logic [IDX_W-1:0] nxt_idx;

    // Clamp a wide signed value to int8; result is {saturated, byte}.
    function automatic logic [8:0] sat8(input logic signed [ACC_W:0] v);
        logic [8:0] res;
        if (v > (ACC_W+1)'(127))
            res = {1'b1, 8'h7f};
        else if (v < (ACC_W+1)'(-128))
            res = {1'b1, 8'h80};
        else
            res = {1'b0, v[7:0]};
        return res;
    endfunction

    // Returns {sat[1:0], data[15:0]}; rounding adds happen one bit wider than the lane.
    function automatic logic [17:0] quantize(input logic [ACC_W-1:0] acc,
                                             input logic sp, input logic [5:0] sh);
        logic [5:0]               s;
        logic signed [ACC_W:0]    w, wr;
        logic signed [LANE_W:0]   l0, l1, lr;
        logic [8:0]               q0, q1;
        if (!sp) begin
            s  = (sh > MAX_S_FULL) ? MAX_S_FULL : sh;
            w  = {acc[ACC_W-1], acc};
            wr = (s == '0) ? '0 : ((ACC_W+1)'(1) << (s - 6'd1));
            w  = (w + wr) >>> s;
            q0 = sat8(w);
            q1 = '0;
        end else begin
            s  = (sh > MAX_S_SPLIT) ? MAX_S_SPLIT : sh;
            lr = (s == '0) ? '0 : ((LANE_W+1)'(1) << (s - 6'd1));
            l0 = {acc[LANE_W-1], acc[LANE_W-1:0]};
            l1 = {acc[ACC_W-1], acc[ACC_W-1:LANE_W]};
            l0 = (l0 + lr) >>> s;
            l1 = (l1 + lr) >>> s;
            q0 = sat8({{(ACC_W-LANE_W){l0[LANE_W]}}, l0});
            q1 = sat8({{(ACC_W-LANE_W){l1[LANE_W]}}, l1});
        end
        return {q1[8], q0[8], q1[7:0], q0[7:0]};
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < NUM_PE; k++)
            in_words[k] = in_acc[k*ACC_W +: ACC_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cap_valid) state_nxt = DRAIN;
            DRAIN:   if (out_ready && out_idx == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_ready = (state == IDLE);
        out_valid = (state == DRAIN);
    end

    assign nxt_idx = out_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_PE; k++) snap[k] <= '0;
            snap_split <= 1'b0;
            snap_shift <= '0;
            out_data   <= '0;
            out_sat    <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            cap_drop   <= 1'b0;
        end else begin
            if (cap_valid && state != IDLE) cap_drop <= 1'b1;
            if (state == IDLE && cap_valid) begin
                // Element 0 is quantized from the live inputs as they are being latched.
                snap       <= in_words;
                snap_split <= split;
                snap_shift <= shift;
                {out_sat, out_data} <= quantize(in_words[0], split, shift);
                out_idx    <= '0;
                out_last   <= (LAST_IDX == '0);
            end else if (state == DRAIN && out_ready && out_idx != LAST_IDX) begin
                {out_sat, out_data} <= quantize(snap[nxt_idx], snap_split, snap_shift);
                out_idx    <= nxt_idx;
                out_last   <= (nxt_idx == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_pe_line_drain.sv
// Randomized bench for pe_line_drain against an integer-arithmetic requantization model.
module tb_pe_line_drain;

    localparam int NUM_PE = 10;
    localparam int ACC_W  = 48;
    localparam int IDX_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    split;
    logic [5:0]              shift;
    logic [NUM_PE*ACC_W-1:0] in_acc;
    logic                    cap_valid;
    logic                    cap_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [15:0]             out_data;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;
    logic [1:0]              out_sat;
    logic                    cap_drop;

    pe_line_drain #(.NUM_PE(NUM_PE), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .split(split), .shift(shift), .in_acc(in_acc),
        .cap_valid(cap_valid), .cap_ready(cap_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_sat(out_sat), .cap_drop(cap_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [47:0] acc_m [NUM_PE];
    bit          split_m;
    int          shift_m;
    bit          exp_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] rq(input longint v, input int s);
        longint r;
        r = (v + ((s > 0) ? (longint'(1) << (s - 1)) : 0)) >>> s;
        if (r > 127)  return {1'b1, 8'h7f};
        if (r < -128) return {1'b1, 8'h80};
        return {1'b0, r[7:0]};
    endfunction

    // {sat1, sat0, lane1, lane0}
    function automatic logic [17:0] model(input logic [47:0] a, input bit sp, input int sh);
        logic [8:0] q0, q1;
        if (!sp) begin
            q0 = rq(longint'($signed(a)), (sh > 47) ? 47 : sh);
            q1 = '0;
        end else begin
            q0 = rq(longint'($signed(a[23:0])),  (sh > 23) ? 23 : sh);
            q1 = rq(longint'($signed(a[47:24])), (sh > 23) ? 23 : sh);
        end
        return {q1[8], q0[8], q1[7:0], q0[7:0]};
    endfunction

    function automatic logic [47:0] rand_acc();
        logic [63:0] t;
        longint v;
        t = {$urandom, $urandom};
        v = $signed(t) >>> $urandom_range(16, 63);
        return v[47:0];
    endfunction

    task automatic scramble_inputs();
        for (int k = 0; k < NUM_PE; k++) in_acc[k*ACC_W +: ACC_W] = rand_acc();
        split = 1'($urandom);
        shift = 6'($urandom);
    endtask

    // Called at a negedge in IDLE; returns at the negedge where beat 0 should be visible.
    task automatic do_capture(input bit sp, input int sh);
        check("cap_ready_idle", 32'(cap_ready), 32'd1);
        split_m = sp;
        shift_m = sh;
        for (int k = 0; k < NUM_PE; k++) in_acc[k*ACC_W +: ACC_W] = acc_m[k];
        split = sp;
        shift = 6'(sh);
        cap_valid = 1'b1;
        @(negedge clk);
        cap_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic drain(input int stall_idx, input int cap_at, input bit rand_ready,
                         output int cycles);
        int exp_idx = 0;
        int stall = 0;
        int budget = 0;
        bit pulsed = 0;
        logic [17:0] e;
        while (exp_idx < NUM_PE && budget < 400) begin
            e = model(acc_m[exp_idx], split_m, shift_m);
            check("valid", 32'(out_valid), 32'd1);
            check("idx",   32'(out_idx),   32'(exp_idx));
            check("data",  32'(out_data),  32'(e[15:0]));
            check("sat",   32'(out_sat),   32'(e[17:16]));
            check("last",  32'(out_last),  32'(exp_idx == NUM_PE - 1));
            check("cap_ready_drain", 32'(cap_ready), 32'd0);
            cap_valid = 1'b0;
            if (exp_idx == cap_at && !pulsed) begin
                cap_valid = 1'b1;
                pulsed = 1;
                exp_drop = 1;
                scramble_inputs();
            end
            if (exp_idx == stall_idx && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_ready) exp_idx++;
            @(negedge clk);
            budget++;
        end
        cap_valid = 1'b0;
        out_ready = 1'($urandom);
        if (budget >= 400) check("drain_timeout", 32'd1, 32'd0);
        cycles = budget;
        check("valid_after", 32'(out_valid), 32'd0);
        check("ready_after", 32'(cap_ready), 32'd1);
        check("cap_drop",    32'(cap_drop),  32'(exp_drop));
    endtask

    task automatic check_reset_vals();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(cap_ready), 32'd1);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_idx",   32'(out_idx),   32'd0);
        check("rst_last",  32'(out_last),  32'd0);
        check("rst_sat",   32'(out_sat),   32'd0);
        check("rst_drop",  32'(cap_drop),  32'd0);
    endtask

    initial begin
        int cyc;
        int k;
        rst = 1'b1;
        cap_valid = 1'b0;
        out_ready = 1'b0;
        in_acc = '0;
        split = 1'b0;
        shift = '0;
        exp_drop = 0;
        #1;
        check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Non-split rounding
        for (int i = 0; i < NUM_PE; i++) acc_m[i] = rand_acc();
        acc_m[0] = 48'd1000;
        acc_m[1] = -48'sd1000;
        acc_m[2] = 48'd5000;
        do_capture(0, 4);
        drain(-1, -1, 0, cyc);

        // Split lanes with backpressure at idx 4
        for (int i = 0; i < NUM_PE; i++) acc_m[i] = rand_acc();
        acc_m[0] = {24'hFFFFFF, 24'd5};
        acc_m[1] = {24'd300, 24'hFFFF00};
        do_capture(1, 0);
        drain(4, -1, 0, cyc);
        check("stall_cycles", 32'(cyc), 32'(NUM_PE + 3));

        // Capture during drain at idx 2, random backpressure
        for (int i = 0; i < NUM_PE; i++) acc_m[i] = rand_acc();
        do_capture(1'($urandom), $urandom_range(0, 63));
        drain(-1, 2, 1, cyc);

        // Capture coinciding with last-beat acceptance
        for (int i = 0; i < NUM_PE; i++) acc_m[i] = rand_acc();
        do_capture(0, $urandom_range(0, 30));
        drain(-1, NUM_PE - 1, 0, cyc);

        // Reset mid-drain at idx 5
        for (int i = 0; i < NUM_PE; i++) acc_m[i] = rand_acc();
        do_capture(1'($urandom), $urandom_range(0, 20));
        out_ready = 1'b1;
        k = 0;
        while (out_idx != 5 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("reach_idx5", 32'(out_idx), 32'd5);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_drop = 0;
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_post_rst", 32'(cap_ready), 32'd1);
        for (int i = 0; i < NUM_PE; i++) acc_m[i] = rand_acc();
        do_capture(1'($urandom), $urandom_range(0, 63));
        drain(-1, -1, 1, cyc);

        // Full-rate stream with shift clamp, then back-to-back capture
        for (int i = 0; i < NUM_PE; i++) acc_m[i] = 48'h7FFF_FFFF_FFFF;
        do_capture(0, 63);
        drain(-1, -1, 0, cyc);
        check("stream_cycles", 32'(cyc), 32'(NUM_PE));
        for (int i = 0; i < NUM_PE; i++) acc_m[i] = rand_acc();
        do_capture(1, 63);
        drain(-1, -1, 0, cyc);
        check("b2b_cycles", 32'(cyc), 32'(NUM_PE));

        // Random snapshots
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NUM_PE; i++) acc_m[i] = rand_acc();
            do_capture(1'($urandom), $urandom_range(0, 63));
            drain($urandom_range(0, NUM_PE - 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, NUM_PE - 1) : -1,
                  1'($urandom), cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
